motion_sequencer: RTL

- Per-frame motion controller for the player sprite.
- Converts the keyboard keycode plus the ground and ceiling contact flags from the collision block into four registered, unsigned per-frame velocity components.
- The collision block consumes those components to produce the next position.
- Owns walk speed, jump launch and decay, gravity ramp, fast-fall and jump re-arm sequencing.
- Sits between the keycode source and the collision/position datapath.

---
 rtl/motion_sequencer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/motion_sequencer.sv
// Per-frame sprite motion controller: keycode plus contact flags in,
// registered unsigned velocity components out, advanced on frame ticks.
module motion_sequencer #(
  parameter int WALK_SPEED   = 2,
  parameter int JUMP_V0      = 9,
  parameter int TERMINAL_V   = 3,
  parameter int DECAY_FRAMES = 6,
  parameter logic [7:0] KEY_LEFT  = 8'h04,
  parameter logic [7:0] KEY_RIGHT = 8'h07,
  parameter logic [7:0] KEY_DOWN  = 8'h16,
  parameter logic [7:0] KEY_JUMP  = 8'h1A
) (
  input  logic       clk_50,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic [7:0] keycode,
  input  logic       on_ground,
  input  logic       hit_ceiling,
  output logic [5:0] Right_V,
  output logic [5:0] Left_V,
  output logic [5:0] Up_V,
  output logic [5:0] Down_V,
  output logic       airborne,
  output logic [1:0] state
);

  localparam logic [1:0] GROUND = 2'd0;
  localparam logic [1:0] RISE   = 2'd1;
  localparam logic [1:0] FALL   = 2'd2;

  localparam logic [5:0] WS   = 6'(WALK_SPEED);
  localparam logic [5:0] V0   = 6'(JUMP_V0);
  localparam logic [5:0] TV   = 6'(TERMINAL_V);
  localparam logic [5:0] LAST = 6'(DECAY_FRAMES - 1);

  logic [1:0] state_n;
  logic [5:0] cnt, cnt_n;
  logic [5:0] up_n, down_n, left_n, right_n;
  logic       armed, armed_n;

  logic launch;
  logic step;
  logic rise_done;
  logic [5:0] up_dec;
  logic [5:0] down_inc;

  assign launch    = on_ground && (keycode == KEY_JUMP) && armed;
  assign step      = (cnt == LAST);
  assign up_dec    = (Up_V == 6'd0) ? 6'd0 : Up_V - 6'd1;
  assign down_inc  = (Down_V >= TV) ? TV : Down_V + 6'd1;
  assign rise_done = step && (up_dec == 6'd0);

  // State and datapath registers; reset wins over the frame tick
  always_ff @(posedge clk_50) begin
    if (Reset) begin
      state    <= GROUND;
      cnt      <= 6'd0;
      Up_V     <= 6'd0;
      Down_V   <= 6'd0;
      Left_V   <= 6'd0;
      Right_V  <= 6'd0;
      airborne <= 1'b0;
      armed    <= 1'b1;
    end else if (frame_tick) begin
      state    <= state_n;
      cnt      <= cnt_n;
      Up_V     <= up_n;
      Down_V   <= down_n;
      Left_V   <= left_n;
      Right_V  <= right_n;
      airborne <= (state_n != GROUND);
      armed    <= armed_n;
    end
  end

  // Next-state selection from contacts, key and decay progress
  always_comb begin
    state_n = state;
    case (state)
      GROUND: begin
        if (launch)          state_n = RISE;
        else if (!on_ground) state_n = FALL;
      end
      RISE: begin
        if (hit_ceiling || rise_done) state_n = FALL;
      end
      FALL: begin
        if (on_ground) state_n = GROUND;
      end
      default: state_n = GROUND;
    endcase
  end

  // Next velocities, decay counter and jump arming
  always_comb begin
    cnt_n   = 6'd0;
    up_n    = 6'd0;
    down_n  = 6'd0;
    left_n  = 6'd0;
    right_n = 6'd0;
    armed_n = (keycode != KEY_JUMP) ? 1'b1 : armed;

    unique case (1'b1)
      keycode == KEY_LEFT:  left_n  = WS;
      keycode == KEY_RIGHT: right_n = WS;
      default: ;
    endcase

    case (state)
      GROUND: begin
        if (launch) begin
          up_n    = V0;
          armed_n = 1'b0;
        end else if (!on_ground) begin
          down_n = 6'd1;
        end
      end
      RISE: begin
        if (hit_ceiling || rise_done) begin
          down_n = 6'd1;
        end else if (step) begin
          up_n = up_dec;
        end else begin
          up_n  = Up_V;
          cnt_n = cnt + 6'd1;
        end
      end
      FALL: begin
        if (!on_ground) begin
          cnt_n  = step ? 6'd0 : cnt + 6'd1;
          down_n = step ? down_inc : Down_V;
          if (keycode == KEY_DOWN) down_n = TV;
        end
      end
      default: ;
    endcase
  end

endmodule
